edge_row_sequencer: RTL and testbench
=====================================

Name: edge_row_sequencer

Overview:
Controller that sequences the EdgeDetection datapath over a full image, one row at a time. It takes a valid/ready pixel stream and drives the detector's reset, enable and input. It pulses the detector's reset between rows, flushes the detector pipeline at row end, and tags the detector outputs with valid, last-column and last-row markers. It sits between the pixel source (line buffer or file reader) and the edge-map sink.

Parameters:
ROW_WIDTH, 150, pixels per row
NUM_ROWS, 150, rows per frame
PIPE_LAT, 2, detector latency in enabled clock edges (>=1)
RST_CYCLES, 1, detector reset cycles between rows (>=1)
CNT_W, 16, width of row/column index outputs

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
start  in  1  one-cycle frame start request
abort  in  1  synchronous frame abort
pix_in  in  8  source pixel
pix_valid  in  1  source pixel valid
pix_ready  out  1  controller accepts pix_in this cycle
det_reset  out  1  to EdgeDetection reset
det_enb  out  1  to EdgeDetection enb
det_data  out  8  to EdgeDetection In_Arrary
det_edges  in  8  from EdgeDetection Edges
out_data  out  8  edge value (0 when out_valid=0)
out_valid  out  1  out_data holds one pixel result
out_last_col  out  1  with out_valid: last pixel of row
out_last_row  out  1  with out_valid: pixel belongs to last row
row_idx  out  CNT_W  current input row
col_idx  out  CNT_W  pixels accepted in current row
busy  out  1  high outside IDLE
done  out  1  one-cycle pulse at frame completion

Behaviour:
- Reset values: state IDLE; pix_ready=0, det_enb=0, det_data=0, out_valid=0, out_last_col=0, out_last_row=0, out_data=0, row_idx=0, col_idx=0, busy=0, done=0. det_reset=1 whenever reset=1.
- States: IDLE, ROW_RST, STREAM, FLUSH, DONE.
- IDLE: if start=1, go to ROW_RST and clear row_idx/col_idx. Otherwise stay.
- ROW_RST: det_reset=1, det_enb=0, pix_ready=0. Clear all tag bits. Stay RST_CYCLES cycles, then go to STREAM.
- STREAM:
  - pix_ready=1.
  - accept = pix_valid & pix_ready.
  - det_enb=accept and det_data=pix_in (combinational).
  - col_idx increments on each accept.
  - On the accept that makes col_idx reach ROW_WIDTH, go to FLUSH.
  - pix_valid=0 stalls the detector: det_enb=0 and the pipeline holds.
- FLUSH: det_enb=1, det_data=0, pix_ready=0. Lasts PIPE_LAT cycles. Then:
  - if row_idx=NUM_ROWS-1, go to DONE;
  - else row_idx++, col_idx=0, go to ROW_RST.
- DONE: done=1 for one cycle, then go to IDLE. row_idx/col_idx keep their final values until the next start.
- Tag pipeline: a shift register tag[1..PIPE_LAT] with fields {v, lc, lr}. It shifts only on edges where det_enb=1.
  - tag[1] loads {accept, col_idx==ROW_WIDTH-1, row_idx==NUM_ROWS-1}; flush bubbles load v=0.
  - A register fresh is set to 1 on an enabled edge and 0 otherwise.
  - out_valid = tag[PIPE_LAT].v & fresh; out_data = det_edges when out_valid, else 0; lc/lr are likewise gated.
  - With no stalls, out_valid rises exactly PIPE_LAT cycles after the accept cycle, and each pixel produces exactly one out_valid.
- start is ignored while busy.
- abort has priority over every transition. The next state is IDLE, with det_enb=0 and tags cleared. No done pulse. Counters keep their values.
- reset mid-frame: next cycle all values equal reset values; the detector is reset through det_reset.
- abort and start together in IDLE: abort wins and the state stays IDLE.
- No sink backpressure: the sink must accept out_valid on every cycle.

Test Plan:
All tests use ROW_WIDTH=4, NUM_ROWS=2, PIPE_LAT=2, RST_CYCLES=1, and a 2-stage enable-gated model detector (Edges = In_Arrary delayed two enabled edges).
1. Basic frame, continuous valid, pixels 10,20,…,80:
   - det_reset high 1 cycle before each row;
   - out_data 10..80 each with one out_valid;
   - out_last_col on 40 and 80; out_last_row on 50..80;
   - done pulses once; busy falls the cycle after done.
2. Stalls: drop pix_valid for 3 cycles after 2nd pixel -> det_enb low those 3 cycles; no duplicate or missing out_valid; output order unchanged.
3. Flush: after the 4th accept of row 0 -> pix_ready=0 for 2 FLUSH cycles plus 1 ROW_RST cycle; det_data=0 during FLUSH; pixel 40 emerges during FLUSH.
4. abort asserted in STREAM at col_idx=2 -> next cycle busy=0, det_enb=0, out_valid=0; no done. A following start runs a clean full frame.
5. start while busy is ignored; reset asserted mid-row -> all outputs at reset values next cycle, det_reset=1 while reset=1.
6. Default parameters, 150×150 ramp -> exactly 22500 out_valid pulses; 150 out_last_col; 150 out_last_row; one done.

Source files
------------

// File: rtl/edge_row_sequencer.sv
// Row-by-row sequencer for the EdgeDetection datapath: takes a valid/ready pixel stream,
// resets the detector between rows, flushes it at row end and tags its outputs.
module edge_row_sequencer #(
    parameter int ROW_WIDTH  = 150,
    parameter int NUM_ROWS   = 150,
    parameter int PIPE_LAT   = 2,
    parameter int RST_CYCLES = 1,
    parameter int CNT_W      = 16,
    parameter int DATA_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] pix_in,
    input  logic              pix_valid,
    output logic              pix_ready,
    output logic              det_reset,
    output logic              det_enb,
    output logic [DATA_W-1:0] det_data,
    input  logic [DATA_W-1:0] det_edges,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_last_col,
    output logic              out_last_row,
    output logic [CNT_W-1:0]  row_idx,
    output logic [CNT_W-1:0]  col_idx,
    output logic              busy,
    output logic              done
);

    localparam int PH_MAX = (PIPE_LAT > RST_CYCLES) ? PIPE_LAT : RST_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX + 1);

    localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(ROW_WIDTH - 1);
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(NUM_ROWS - 1);
    localparam logic [PH_W-1:0]  RST_END  = PH_W'(RST_CYCLES - 1);
    localparam logic [PH_W-1:0]  FL_END   = PH_W'(PIPE_LAT - 1);

    typedef enum logic [2:0] {
        IDLE,
        ROW_RST,
        STREAM,
        FLUSH,
        DONE
    } state_t;

    state_t           state;
    logic [PH_W-1:0]  ph_cnt;
    logic             accept;

    // Tag shadow of the detector pipeline; index PIPE_LAT lines up with det_edges.
    logic [PIPE_LAT:1] tag_vld;
    logic [PIPE_LAT:1] tag_lc;
    logic [PIPE_LAT:1] tag_lr;
    logic              fresh;

    // abort also blocks the handshake in its own cycle so no pixel is half-consumed
    always_comb begin
        pix_ready    = (state == STREAM) && !abort;
        accept       = pix_ready && pix_valid;
        det_reset    = reset || (state == ROW_RST);
        det_enb      = accept || ((state == FLUSH) && !abort);
        det_data     = (state == STREAM) ? pix_in : '0;
        busy         = (state != IDLE);
        done         = (state == DONE);
        out_valid    = tag_vld[PIPE_LAT] && fresh;
        out_data     = out_valid ? det_edges : '0;
        out_last_col = out_valid && tag_lc[PIPE_LAT];
        out_last_row = out_valid && tag_lr[PIPE_LAT];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            ph_cnt  <= '0;
            row_idx <= '0;
            col_idx <= '0;
        end else if (abort) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        row_idx <= '0;
                        col_idx <= '0;
                        ph_cnt  <= '0;
                        state   <= ROW_RST;
                    end
                end
                ROW_RST: begin
                    if (ph_cnt == RST_END) begin
                        ph_cnt <= '0;
                        state  <= STREAM;
                    end else begin
                        ph_cnt <= ph_cnt + PH_W'(1);
                    end
                end
                STREAM: begin
                    if (accept) begin
                        col_idx <= col_idx + CNT_W'(1);
                        if (col_idx == LAST_COL) state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (ph_cnt == FL_END) begin
                        ph_cnt <= '0;
                        if (row_idx == LAST_ROW) begin
                            state <= DONE;
                        end else begin
                            row_idx <= row_idx + CNT_W'(1);
                            col_idx <= '0;
                            state   <= ROW_RST;
                        end
                    end else begin
                        ph_cnt <= ph_cnt + PH_W'(1);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Tags advance only on enabled edges, exactly like the detector's own registers
    always_ff @(posedge clk) begin
        if (reset || abort || (state == ROW_RST)) begin
            tag_vld <= '0;
            tag_lc  <= '0;
            tag_lr  <= '0;
            fresh   <= 1'b0;
        end else begin
            fresh <= det_enb;
            if (det_enb) begin
                tag_vld[1] <= accept;
                tag_lc[1]  <= accept && (col_idx == LAST_COL);
                tag_lr[1]  <= accept && (row_idx == LAST_ROW);
                for (int i = 2; i <= PIPE_LAT; i++) begin
                    tag_vld[i] <= tag_vld[i-1];
                    tag_lc[i]  <= tag_lc[i-1];
                    tag_lr[i]  <= tag_lr[i-1];
                end
            end
        end
    end

endmodule

// File: tb/tb_edge_row_sequencer.sv
// Bench for edge_row_sequencer: a 4x2 instance with a 2-stage enable-gated detector model,
// plus a default 150x150 instance streaming a ramp.
module tb_edge_row_sequencer;

    localparam int W  = 4;
    localparam int NR = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  pix_in = 8'd0;
    logic        pix_valid = 1'b0;
    logic        pix_ready, det_reset, det_enb;
    logic [7:0]  det_data, det_edges, out_data;
    logic        out_valid, out_last_col, out_last_row, busy, done;
    logic [15:0] row_idx, col_idx;

    edge_row_sequencer #(.ROW_WIDTH(W), .NUM_ROWS(NR), .PIPE_LAT(2), .RST_CYCLES(1), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .det_reset(det_reset), .det_enb(det_enb), .det_data(det_data), .det_edges(det_edges),
        .out_data(out_data), .out_valid(out_valid), .out_last_col(out_last_col),
        .out_last_row(out_last_row), .row_idx(row_idx), .col_idx(col_idx),
        .busy(busy), .done(done)
    );

    // Detector model: Edges = In_Arrary delayed two enabled edges
    logic [7:0] d1, d2;
    always @(posedge clk) begin
        if (det_reset) begin
            d1 <= 8'd0; d2 <= 8'd0;
        end else if (det_enb) begin
            d1 <= det_data; d2 <= d1;
        end
    end
    assign det_edges = d2;

    // Default-size instance
    logic        b_start = 1'b0;
    logic        b_abort = 1'b0;
    logic [7:0]  b_pix_in = 8'd0;
    logic        b_pix_valid = 1'b0;
    logic        b_pix_ready, b_det_reset, b_det_enb;
    logic [7:0]  b_det_data, b_det_edges, b_out_data;
    logic        b_out_valid, b_out_last_col, b_out_last_row, b_busy, b_done;
    logic [15:0] b_row_idx, b_col_idx;

    edge_row_sequencer u_big (
        .clk(clk), .reset(reset), .start(b_start), .abort(b_abort),
        .pix_in(b_pix_in), .pix_valid(b_pix_valid), .pix_ready(b_pix_ready),
        .det_reset(b_det_reset), .det_enb(b_det_enb), .det_data(b_det_data), .det_edges(b_det_edges),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_last_col(b_out_last_col),
        .out_last_row(b_out_last_row), .row_idx(b_row_idx), .col_idx(b_col_idx),
        .busy(b_busy), .done(b_done)
    );

    logic [7:0] bd1, bd2;
    always @(posedge clk) begin
        if (b_det_reset) begin
            bd1 <= 8'd0; bd2 <= 8'd0;
        end else if (b_det_enb) begin
            bd1 <= b_det_data; bd2 <= bd1;
        end
    end
    assign b_det_edges = bd2;

    // Recorder
    typedef struct packed {
        logic [7:0]  d;
        logic        lc;
        logic        lr;
        logic [31:0] c;
    } ev_t;

    int   cyc = 0;
    ev_t  obs[$];
    int   acc_cyc[$];
    int   done_cnt = 0;
    int   done_cyc = 0;
    bit   enb_log  [0:32767];
    bit   rdy_log  [0:32767];
    bit   rst_log  [0:32767];
    bit   dz_log   [0:32767];
    bit   busy_log [0:32767];

    int   b_nv = 0, b_nlc = 0, b_nlr = 0, b_ndone = 0, b_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid) obs.push_back('{d: out_data, lc: out_last_col, lr: out_last_row, c: cyc});
        if (pix_ready && pix_valid) acc_cyc.push_back(cyc);
        if (done) begin done_cnt++; done_cyc = cyc; end
        enb_log[cyc & 32767]  = det_enb;
        rdy_log[cyc & 32767]  = pix_ready;
        rst_log[cyc & 32767]  = det_reset;
        dz_log[cyc & 32767]   = (det_data == 8'd0);
        busy_log[cyc & 32767] = busy;
        if (b_out_valid) begin
            if (b_out_data !== 8'(b_nv % 256) || b_out_last_col !== (b_nv % 150 == 149) ||
                b_out_last_row !== (b_nv / 150 == 149)) b_bad++;
            b_nv++;
            if (b_out_last_col) b_nlc++;
            if (b_out_last_row) b_nlr++;
        end
        if (b_done) b_ndone++;
    end

    int passed = 0;
    int total  = 0;
    logic [7:0] px[$];

    // Reference: k-th output of a frame is the k-th pixel offered, tagged from its raster position
    function automatic int frame_errors(input int obase);
        int n = 0;
        if (obs.size() != obase + W * NR) n++;
        for (int k = 0; k < W * NR; k++) begin
            if (obase + k < obs.size()) begin
                if (obs[obase+k].d !== px[k] || obs[obase+k].lc !== (k % W == W - 1) ||
                    obs[obase+k].lr !== (k / W == NR - 1)) n++;
            end else begin
                n++;
            end
        end
        return n;
    endfunction

    // evt_kind: 0 none, 1 abort, 2 reset, 3 start while busy; fires when evt_at pixels are accepted
    task automatic drive_frame(input bit fixed, input int stall_after, input int stall_len,
                               input int evt_at, input int evt_kind, output bit ok);
        int i = 0;
        int stall = 0;
        int guard = 0;
        ok = 1'b0;
        px.delete();
        for (int k = 0; k < W * NR; k++)
            px.push_back(fixed ? 8'(10 * (k + 1)) : 8'($urandom_range(1, 255)));
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (i < W * NR && guard < 400) begin
            guard++;
            if ((evt_kind == 1 || evt_kind == 2) && i == evt_at) begin
                pix_valid = 1'b0;
                if (evt_kind == 1) abort = 1'b1; else reset = 1'b1;
                ok = 1'b1;
                return;
            end
            start     = (evt_kind == 3) && (i == evt_at);
            pix_valid = (stall == 0);
            pix_in    = px[i];
            @(negedge clk);
            if (pix_valid && pix_ready) begin
                i++;
                if (i == stall_after) stall = stall_len;
            end else if (stall > 0) begin
                stall--;
            end
            @(posedge clk); #1;
        end
        pix_valid = 1'b0;
        start     = 1'b0;
        guard     = 0;
        while (busy && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        repeat (2) @(posedge clk);
        #1;
        ok = (i == W * NR) && !busy;
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++;
        if (det_reset !== 1'b1) $display("FAIL reset_det_reset got %b want 1", det_reset);
        else passed++;
        total++;
        if ({pix_ready, det_enb, out_valid, out_last_col, out_last_row, busy, done} !== 7'b0)
            $display("FAIL reset_flags got %b want 0000000",
                     {pix_ready, det_enb, out_valid, out_last_col, out_last_row, busy, done});
        else passed++;
        total++;
        if ({row_idx, col_idx} !== 32'd0) $display("FAIL reset_idx got %0d/%0d want 0/0", row_idx, col_idx);
        else passed++;
        total++;
        if ({det_data, out_data} !== 16'd0) $display("FAIL reset_data got %h/%h want 0/0", det_data, out_data);
        else passed++;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        bit ok;
        int obase = obs.size();
        int abase = acc_cyc.size();
        int dbase = done_cnt;
        int c0 = cyc;
        int nrst = 0;
        int late = 0;
        drive_frame(1'b1, -1, 0, -1, 0, ok);
        total++;
        if (!ok) $display("FAIL basic_complete got ok=%b want 1", ok); else passed++;
        total++;
        if (frame_errors(obase) != 0) $display("FAIL basic_outputs got %0d bad want 0", frame_errors(obase));
        else passed++;
        for (int k = 0; k < W * NR; k++)
            if (obase + k >= obs.size() || abase + k >= acc_cyc.size() ||
                int'(obs[obase+k].c) != acc_cyc[abase+k] + 2) late++;
        total++;
        if (late != 0) $display("FAIL basic_latency got %0d off-time outputs want 0", late); else passed++;
        for (int c = c0; c <= done_cyc; c++) nrst += int'(rst_log[c & 32767]);
        total++;
        if (nrst != NR || !rst_log[(acc_cyc[abase] - 1) & 32767] || !rst_log[(acc_cyc[abase+W] - 1) & 32767])
            $display("FAIL basic_det_reset got %0d cycles want %0d, one before each row", nrst, NR);
        else passed++;
        total++;
        if (done_cnt - dbase != 1) $display("FAIL basic_done got %0d pulses want 1", done_cnt - dbase);
        else passed++;
        total++;
        if ({busy_log[done_cyc & 32767], busy_log[(done_cyc + 1) & 32767]} !== 2'b10)
            $display("FAIL basic_busy_fall got %b want 10",
                     {busy_log[done_cyc & 32767], busy_log[(done_cyc + 1) & 32767]});
        else passed++;
    endtask

    task automatic test_stall();
        bit ok;
        int obase = obs.size();
        int abase = acc_cyc.size();
        int a1;
        drive_frame(1'b0, 2, 3, -1, 0, ok);
        a1 = acc_cyc[abase+1];
        total++;
        if (acc_cyc[abase+2] - a1 != 4) $display("FAIL stall_gap got %0d want 4", acc_cyc[abase+2] - a1);
        else passed++;
        total++;
        if ({enb_log[(a1+1) & 32767], enb_log[(a1+2) & 32767], enb_log[(a1+3) & 32767]} !== 3'b000)
            $display("FAIL stall_det_enb got %b want 000",
                     {enb_log[(a1+1) & 32767], enb_log[(a1+2) & 32767], enb_log[(a1+3) & 32767]});
        else passed++;
        total++;
        if (!ok || frame_errors(obase) != 0)
            $display("FAIL stall_outputs got %0d bad (ok=%b) want 0", frame_errors(obase), ok);
        else passed++;
    endtask

    task automatic test_flush();
        bit ok;
        int obase = obs.size();
        int abase = acc_cyc.size();
        int c;
        drive_frame(1'b0, -1, 0, -1, 0, ok);
        c = acc_cyc[abase+3];
        total++;
        if ({rdy_log[(c+1) & 32767], rdy_log[(c+2) & 32767], rdy_log[(c+3) & 32767], rdy_log[(c+4) & 32767]} !== 4'b0001)
            $display("FAIL flush_ready got %b want 0001",
                     {rdy_log[(c+1) & 32767], rdy_log[(c+2) & 32767], rdy_log[(c+3) & 32767], rdy_log[(c+4) & 32767]});
        else passed++;
        total++;
        if ({dz_log[(c+1) & 32767], dz_log[(c+2) & 32767], enb_log[(c+1) & 32767], enb_log[(c+2) & 32767]} !== 4'b1111)
            $display("FAIL flush_data_enb got %b want 1111",
                     {dz_log[(c+1) & 32767], dz_log[(c+2) & 32767], enb_log[(c+1) & 32767], enb_log[(c+2) & 32767]});
        else passed++;
        total++;
        if (obs.size() <= obase + 3 || int'(obs[obase+3].c) != c + 2)
            $display("FAIL flush_last_pixel got cycle %0d want %0d",
                     (obs.size() > obase + 3) ? int'(obs[obase+3].c) : -1, c + 2);
        else passed++;
        total++;
        if (!ok || frame_errors(obase) != 0)
            $display("FAIL flush_outputs got %0d bad (ok=%b) want 0", frame_errors(obase), ok);
        else passed++;
    endtask

    task automatic test_abort();
        bit ok;
        int dbase = done_cnt;
        int obase;
        drive_frame(1'b0, -1, 0, 2, 1, ok);
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        total++;
        if ({busy, det_enb, out_valid} !== 3'b000)
            $display("FAIL abort_next got busy/enb/valid %b want 000", {busy, det_enb, out_valid});
        else passed++;
        total++;
        if (col_idx !== 16'd2) $display("FAIL abort_col_kept got %0d want 2", col_idx); else passed++;
        repeat (5) @(posedge clk);
        #1;
        total++;
        if (done_cnt != dbase || busy !== 1'b0)
            $display("FAIL abort_no_done got %0d pulses busy=%b want 0/0", done_cnt - dbase, busy);
        else passed++;
        obase = obs.size();
        dbase = done_cnt;
        drive_frame(1'b0, -1, 0, -1, 0, ok);
        total++;
        if (!ok || frame_errors(obase) != 0 || done_cnt - dbase != 1)
            $display("FAIL abort_restart got %0d bad, %0d done want 0, 1", frame_errors(obase), done_cnt - dbase);
        else passed++;
    endtask

    task automatic test_start_busy_and_reset();
        bit ok;
        int obase = obs.size();
        int dbase = done_cnt;
        drive_frame(1'b0, -1, 0, 1, 3, ok);
        total++;
        if (!ok || frame_errors(obase) != 0 || done_cnt - dbase != 1)
            $display("FAIL start_busy got %0d bad, %0d done want 0, 1", frame_errors(obase), done_cnt - dbase);
        else passed++;
        drive_frame(1'b0, -1, 0, 2, 2, ok);
        @(negedge clk);
        total++;
        if (det_reset !== 1'b1) $display("FAIL midreset_det_reset got %b want 1", det_reset); else passed++;
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if ({busy, pix_ready, det_enb, out_valid, done, row_idx, col_idx, out_data, det_data} !== 53'd0)
            $display("FAIL midreset_state got busy=%b rdy=%b enb=%b ov=%b row=%0d col=%0d want all 0",
                     busy, pix_ready, det_enb, out_valid, row_idx, col_idx);
        else passed++;
        total++;
        if (det_reset !== 1'b1) $display("FAIL midreset_det_reset_hold got %b want 1", det_reset); else passed++;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_full_frame();
        int bi = 0;
        int guard = 0;
        b_start = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0;
        while (bi < 22500 && guard < 30000) begin
            guard++;
            b_pix_valid = 1'b1;
            b_pix_in    = 8'(bi % 256);
            @(negedge clk);
            if (b_pix_valid && b_pix_ready) bi++;
            @(posedge clk); #1;
        end
        b_pix_valid = 1'b0;
        guard = 0;
        while (b_busy && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (bi != 22500 || b_busy !== 1'b0) $display("FAIL full_accepted got %0d busy=%b want 22500/0", bi, b_busy);
        else passed++;
        total++;
        if (b_nv != 22500) $display("FAIL full_valid_count got %0d want 22500", b_nv); else passed++;
        total++;
        if (b_nlc != 150) $display("FAIL full_last_col got %0d want 150", b_nlc); else passed++;
        total++;
        if (b_nlr != 150) $display("FAIL full_last_row got %0d want 150", b_nlr); else passed++;
        total++;
        if (b_ndone != 1) $display("FAIL full_done got %0d want 1", b_ndone); else passed++;
        total++;
        if (b_bad != 0) $display("FAIL full_data got %0d bad want 0", b_bad); else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_flush();
        test_abort();
        test_start_busy_and_reset();
        test_full_frame();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
